// File: rtl/snn_ff_pkg.sv
// Shared types and derived-constant helpers for the synaptic update controller.
package snn_ff_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } upd_state_t;

  // Number of SRAM words per pre-synaptic neuron.
  function automatic int unsigned groups_of(int unsigned out_n, int unsigned par);
    return out_n / par;
  endfunction

  // Total number of synaptic words swept by one update.
  function automatic int unsigned depth_of(int unsigned in_n, int unsigned out_n,
                                           int unsigned par);
    return in_n * groups_of(out_n, par);
  endfunction

  // Counter width for a 0..n-1 range; never zero bits wide.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned GROUPS = groups_of(256, 4);
  localparam int unsigned DEPTH  = depth_of(784, 256, 4);

endpackage

// File: rtl/synaptic_update_ctrl_if.sv
// SRAM bus and inference-read handshake between controller and synaptic core.
interface synaptic_update_ctrl_if #(
  parameter int unsigned SYN_ADDR_WIDTH  = 16,
  parameter int unsigned GRAD_ADDR_WIDTH = 16
) ();
  logic                       INF_REQ;
  logic [SYN_ADDR_WIDTH-1:0]  INF_ADDR;
  logic                       INF_GNT;
  logic                       CTRL_SYNARRAY_CS;
  logic                       CTRL_SYNARRAY_WE;
  logic [SYN_ADDR_WIDTH-1:0]  CTRL_SYNARRAY_ADDR;
  logic                       CTRL_GRAD_ARRAY_CS;
  logic                       CTRL_GRAD_ARRAY_WE;
  logic [GRAD_ADDR_WIDTH-1:0] CTRL_GRAD_ARRAY_ADDR;

  modport master (
    input  INF_REQ, INF_ADDR,
    output INF_GNT,
    output CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE, CTRL_SYNARRAY_ADDR,
    output CTRL_GRAD_ARRAY_CS, CTRL_GRAD_ARRAY_WE, CTRL_GRAD_ARRAY_ADDR
  );

  modport slave (
    output INF_REQ, INF_ADDR,
    input  INF_GNT,
    input  CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE, CTRL_SYNARRAY_ADDR,
    input  CTRL_GRAD_ARRAY_CS, CTRL_GRAD_ARRAY_WE, CTRL_GRAD_ARRAY_ADDR
  );
endinterface

// File: rtl/synaptic_sweep_counter.sv
// Nested group/pre-neuron counter alongside a linear word address.
// The linear counter tracks pre_idx*GROUPS+grp_idx without a multiplier.
module synaptic_sweep_counter
  import snn_ff_pkg::*;
#(
  parameter int unsigned N_GROUPS = 2,
  parameter int unsigned N_DEPTH  = 8,
  parameter int unsigned N_PRE    = 4,
  localparam int unsigned ADDR_CW = cnt_width(N_DEPTH),
  localparam int unsigned GRP_CW  = cnt_width(N_GROUPS),
  localparam int unsigned PRE_CW  = cnt_width(N_PRE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               advance,
  output logic [ADDR_CW-1:0] addr_cnt,
  output logic [GRP_CW-1:0]  grp_idx,
  output logic [PRE_CW-1:0]  pre_idx,
  output logic               last_word
);
  localparam logic [ADDR_CW-1:0] ADDR_LAST = ADDR_CW'(N_DEPTH - 1);
  localparam logic [GRP_CW-1:0]  GRP_LAST  = GRP_CW'(N_GROUPS - 1);

  // Step to the next word; group index wraps into the pre-neuron index.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      addr_cnt <= '0;
      grp_idx  <= '0;
      pre_idx  <= '0;
    end else if (advance) begin
      addr_cnt <= addr_cnt + 1'b1;
      if (grp_idx == GRP_LAST) begin
        grp_idx <= '0;
        pre_idx <= pre_idx + 1'b1;
      end else begin
        grp_idx <= grp_idx + 1'b1;
      end
    end
  end

  assign last_word = (addr_cnt == ADDR_LAST);

endmodule

// File: rtl/synaptic_update_ctrl.sv
// Weight/gradient SRAM sweep sequencer with idle-time inference read arbitration.
module synaptic_update_ctrl
  import snn_ff_pkg::*;
#(
  parameter int unsigned INPUT_NEURON          = 784,
  parameter int unsigned OUTPUT_NEURON         = 256,
  parameter int unsigned POST_NEUR_PARALLEL    = 4,
  parameter int unsigned PRE_NEUR_ADDR_WIDTH   = 10,
  parameter int unsigned POST_NEUR_ADDR_WIDTH  = 10,
  parameter int unsigned SYN_ARRAY_ADDR_WIDTH  = 16,
  parameter int unsigned GRAD_ARRAY_ADDR_WIDTH = 16
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            IS_TRAIN,
  input  logic                            SPI_GATE_ACTIVITY_sync,
  input  logic                            UPDATE_START,
  output logic                            UPDATE_BUSY,
  output logic                            UPDATE_DONE,
  output logic [PRE_NEUR_ADDR_WIDTH-1:0]  CTRL_PRE_NEURON_ADDRESS,
  output logic [POST_NEUR_ADDR_WIDTH-1:0] CTRL_POST_NEURON_ADDRESS,
  synaptic_update_ctrl_if.master          bus
);
  localparam int unsigned N_GROUPS = groups_of(OUTPUT_NEURON, POST_NEUR_PARALLEL);
  localparam int unsigned N_DEPTH  = depth_of(INPUT_NEURON, OUTPUT_NEURON, POST_NEUR_PARALLEL);
  localparam int unsigned ADDR_CW  = cnt_width(N_DEPTH);
  localparam int unsigned GRP_CW   = cnt_width(N_GROUPS);
  localparam int unsigned PRE_CW   = cnt_width(INPUT_NEURON);

  upd_state_t         state;
  logic [ADDR_CW-1:0] addr_cnt;
  logic [GRP_CW-1:0]  grp_idx;
  logic [PRE_CW-1:0]  pre_idx;
  logic               last_word;
  logic               go;
  logic               advance;

  assign go      = (state == IDLE) && UPDATE_START && IS_TRAIN && !SPI_GATE_ACTIVITY_sync;
  assign advance = (state == WR) && !last_word;

  synaptic_sweep_counter #(
    .N_GROUPS (N_GROUPS),
    .N_DEPTH  (N_DEPTH),
    .N_PRE    (INPUT_NEURON)
  ) u_cnt (
    .clk       (CLK),
    .rst       (RST),
    .clear     (go),
    .advance   (advance),
    .addr_cnt  (addr_cnt),
    .grp_idx   (grp_idx),
    .pre_idx   (pre_idx),
    .last_word (last_word)
  );

  // Sweep sequencing: read, write-back, per word; gate pauses only in RD.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (go) state <= RD;
        RD:      if (!SPI_GATE_ACTIVITY_sync) state <= WR;
        WR:      state <= last_word ? DONE : RD;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode and arbitration mux; everything is forced low while RST is high.
  always_comb begin
    UPDATE_BUSY              = 1'b0;
    UPDATE_DONE              = 1'b0;
    bus.INF_GNT              = 1'b0;
    bus.CTRL_SYNARRAY_CS     = 1'b0;
    bus.CTRL_SYNARRAY_WE     = 1'b0;
    bus.CTRL_SYNARRAY_ADDR   = '0;
    bus.CTRL_GRAD_ARRAY_CS   = 1'b0;
    bus.CTRL_GRAD_ARRAY_WE   = 1'b0;
    bus.CTRL_GRAD_ARRAY_ADDR = '0;
    CTRL_PRE_NEURON_ADDRESS  = '0;
    CTRL_POST_NEURON_ADDRESS = '0;
    if (!RST) begin
      CTRL_PRE_NEURON_ADDRESS  = PRE_NEUR_ADDR_WIDTH'(pre_idx);
      CTRL_POST_NEURON_ADDRESS = POST_NEUR_ADDR_WIDTH'(grp_idx)
                               * POST_NEUR_ADDR_WIDTH'(POST_NEUR_PARALLEL);
      case (state)
        IDLE: begin
          if (bus.INF_REQ) begin
            bus.INF_GNT            = 1'b1;
            bus.CTRL_SYNARRAY_CS   = 1'b1;
            bus.CTRL_SYNARRAY_ADDR = bus.INF_ADDR;
          end
        end
        RD: begin
          UPDATE_BUSY              = 1'b1;
          bus.CTRL_SYNARRAY_CS     = !SPI_GATE_ACTIVITY_sync;
          bus.CTRL_GRAD_ARRAY_CS   = !SPI_GATE_ACTIVITY_sync;
          bus.CTRL_SYNARRAY_ADDR   = SYN_ARRAY_ADDR_WIDTH'(addr_cnt);
          bus.CTRL_GRAD_ARRAY_ADDR = GRAD_ARRAY_ADDR_WIDTH'(addr_cnt);
        end
        WR: begin
          UPDATE_BUSY              = 1'b1;
          bus.CTRL_SYNARRAY_CS     = 1'b1;
          bus.CTRL_SYNARRAY_WE     = 1'b1;
          bus.CTRL_GRAD_ARRAY_CS   = 1'b1;
          bus.CTRL_GRAD_ARRAY_WE   = 1'b1;
          bus.CTRL_SYNARRAY_ADDR   = SYN_ARRAY_ADDR_WIDTH'(addr_cnt);
          bus.CTRL_GRAD_ARRAY_ADDR = GRAD_ARRAY_ADDR_WIDTH'(addr_cnt);
        end
        DONE:    UPDATE_DONE = 1'b1;
        default: UPDATE_DONE = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_synaptic_update_ctrl.sv
// Self-checking bench for synaptic_update_ctrl (4 pre, 8 post, 4 per word).
module tb_synaptic_update_ctrl;
  localparam int IN_N = 4;
  localparam int OUT_N = 8;
  localparam int PAR = 4;
  localparam int G = OUT_N / PAR;
  localparam int D = IN_N * G;

  logic clk, rst, train, gate, start;
  logic busy, done;
  logic [9:0] pre_a, post_a;

  synaptic_update_ctrl_if #(.SYN_ADDR_WIDTH(16), .GRAD_ADDR_WIDTH(16)) bus_if ();

  synaptic_update_ctrl #(
    .INPUT_NEURON(IN_N), .OUTPUT_NEURON(OUT_N), .POST_NEUR_PARALLEL(PAR),
    .PRE_NEUR_ADDR_WIDTH(10), .POST_NEUR_ADDR_WIDTH(10),
    .SYN_ARRAY_ADDR_WIDTH(16), .GRAD_ARRAY_ADDR_WIDTH(16)
  ) dut (
    .CLK(clk), .RST(rst), .IS_TRAIN(train), .SPI_GATE_ACTIVITY_sync(gate),
    .UPDATE_START(start), .UPDATE_BUSY(busy), .UPDATE_DONE(done),
    .CTRL_PRE_NEURON_ADDRESS(pre_a), .CTRL_POST_NEURON_ADDRESS(post_a),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: sweep mode (0 idle, 1 sweeping, 2 done pulse), word index, write half.
  int m_mode = 0;
  int m_word = 0;
  bit m_wr = 0;

  // Observation bookkeeping
  int cyc = 0, done_cnt = 0, done_cyc = -1, busy_start = -1, cs_cnt = 0;
  bit prev_busy = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Compare one cycle against the model, then advance model across the clock edge.
  task automatic tick();
    bit e_busy, e_done, e_gnt, e_cs, e_we, e_gcs;
    int e_addr;
    #1;
    e_busy = 0; e_done = 0; e_gnt = 0; e_cs = 0; e_we = 0; e_gcs = 0; e_addr = 0;
    if (!rst) begin
      case (m_mode)
        0: begin e_gnt = bus_if.INF_REQ; e_cs = bus_if.INF_REQ; e_addr = bus_if.INF_ADDR; end
        1: begin
          e_busy = 1; e_addr = m_word;
          e_cs = m_wr ? 1'b1 : !gate; e_gcs = e_cs; e_we = m_wr;
        end
        default: e_done = 1;
      endcase
    end
    check("busy", busy, e_busy);
    check("done", done, e_done);
    check("inf_gnt", bus_if.INF_GNT, e_gnt);
    check("syn_cs", bus_if.CTRL_SYNARRAY_CS, e_cs);
    check("syn_we", bus_if.CTRL_SYNARRAY_WE, e_we);
    check("grad_cs", bus_if.CTRL_GRAD_ARRAY_CS, e_gcs);
    check("grad_we", bus_if.CTRL_GRAD_ARRAY_WE, e_we);
    if (e_cs) check("syn_addr", bus_if.CTRL_SYNARRAY_ADDR, e_addr);
    if (e_gcs) check("grad_addr", bus_if.CTRL_GRAD_ARRAY_ADDR, e_addr);
    if (rst) begin
      check("rst_syn_addr", bus_if.CTRL_SYNARRAY_ADDR, 0);
      check("rst_pre", pre_a, 0);
      check("rst_post", post_a, 0);
    end else if (m_mode == 1) begin
      check("pre_addr", pre_a, m_word / G);
      check("post_addr", post_a, (m_word % G) * PAR);
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy && !prev_busy) busy_start = cyc;
    prev_busy = busy;
    if (bus_if.CTRL_SYNARRAY_CS) cs_cnt++;
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_word = 0; m_wr = 0;
    end else begin
      case (m_mode)
        0: if (start && train && !gate) begin m_mode = 1; m_word = 0; m_wr = 0; end
        1: if (!m_wr) begin
             if (!gate) m_wr = 1;
           end else if (m_word == D - 1) m_mode = 2;
           else begin m_word++; m_wr = 0; end
        default: m_mode = 0;
      endcase
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_to_done(input string name);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < 200) begin tick(); n++; end
    check({name, "_done_seen"}, done_cnt - d0, 1);
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  typedef struct { bit cs; bit we; int addr; int pre; int post; bit dn; } vec_t;
  vec_t tbl [17];

  initial begin
    int n, d0, c0;
    tbl = '{'{1,0,0,0,0,0}, '{1,1,0,0,0,0}, '{1,0,1,0,4,0}, '{1,1,1,0,4,0},
            '{1,0,2,1,0,0}, '{1,1,2,1,0,0}, '{1,0,3,1,4,0}, '{1,1,3,1,4,0},
            '{1,0,4,2,0,0}, '{1,1,4,2,0,0}, '{1,0,5,2,4,0}, '{1,1,5,2,4,0},
            '{1,0,6,3,0,0}, '{1,1,6,3,0,0}, '{1,0,7,3,4,0}, '{1,1,7,3,4,0},
            '{0,0,0,3,4,1}};
    rst = 1; train = 0; gate = 0; start = 0;
    bus_if.INF_REQ = 0; bus_if.INF_ADDR = '0;
    @(negedge clk);
    repeat (2) tick();
    rst = 0;
    tick();

    // Basic sweep against the literal vector table
    train = 1;
    pulse_start();
    for (int i = 0; i < 17; i++) begin
      #1;
      check("tbl_cs", bus_if.CTRL_SYNARRAY_CS, tbl[i].cs);
      check("tbl_we", bus_if.CTRL_SYNARRAY_WE, tbl[i].we);
      if (tbl[i].cs) check("tbl_addr", bus_if.CTRL_SYNARRAY_ADDR, tbl[i].addr);
      check("tbl_pre", pre_a, tbl[i].pre);
      check("tbl_post", post_a, tbl[i].post);
      check("tbl_done", done, tbl[i].dn);
      tick();
    end
    // First RD to DONE spans 2*D+1 cycles inclusive
    check("sweep_len", done_cyc - busy_start, 2 * D);
    tick();

    // Training disabled: START ignored
    train = 0; c0 = cs_cnt;
    pulse_start();
    repeat (4) tick();
    check("notrain_cs", cs_cnt - c0, 0);
    check("notrain_busy", busy, 0);
    train = 1;

    // Gate pause at word 3 during RD
    pulse_start();
    n = 0;
    while (!(m_mode == 1 && !m_wr && m_word == 3) && n < 100) begin tick(); n++; end
    check("wait_rd3", n < 100, 1);
    gate = 1;
    repeat (5) tick();
    gate = 0;
    #1;
    check("resume_cs", bus_if.CTRL_SYNARRAY_CS, 1);
    check("resume_addr", bus_if.CTRL_SYNARRAY_ADDR, 3);
    run_to_done("gate");
    check("gate_len", done_cyc - busy_start, 2 * D + 5);
    tick();

    // Inference request held during a sweep is granted right after DONE
    pulse_start();
    bus_if.INF_REQ = 1; bus_if.INF_ADDR = 16'd5;
    n = 0;
    while (n < 200) begin
      #1;
      if (bus_if.INF_GNT) break;
      tick(); n++;
    end
    check("gnt_after_done", cyc, done_cyc + 1);
    check("gnt_cs", bus_if.CTRL_SYNARRAY_CS, 1);
    check("gnt_we", bus_if.CTRL_SYNARRAY_WE, 0);
    check("gnt_addr", bus_if.CTRL_SYNARRAY_ADDR, 5);
    check("gnt_grad_cs", bus_if.CTRL_GRAD_ARRAY_CS, 0);
    tick();
    bus_if.INF_REQ = 0;
    tick();

    // Simultaneous START and INF_REQ in IDLE
    start = 1; bus_if.INF_REQ = 1; bus_if.INF_ADDR = 16'd9;
    #1;
    check("sim_gnt", bus_if.INF_GNT, 1);
    check("sim_addr", bus_if.CTRL_SYNARRAY_ADDR, 9);
    tick();
    start = 0; bus_if.INF_REQ = 0;
    #1;
    check("sim_busy", busy, 1);
    check("sim_rd_addr", bus_if.CTRL_SYNARRAY_ADDR, 0);
    check("sim_nognt", bus_if.INF_GNT, 0);
    run_to_done("sim");
    tick();

    // Reset in WR of word 4, then restart from word 0
    pulse_start();
    n = 0;
    while (!(m_mode == 1 && m_wr && m_word == 4) && n < 100) begin tick(); n++; end
    check("wait_wr4", n < 100, 1);
    rst = 1; tick(); rst = 0;
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_cs", bus_if.CTRL_SYNARRAY_CS, 0);
    check("post_rst_pre", pre_a, 0);
    pulse_start();
    #1;
    check("restart_addr", bus_if.CTRL_SYNARRAY_ADDR, 0);
    check("restart_busy", busy, 1);
    run_to_done("restart");
    tick();

    // Second START while busy is ignored
    d0 = done_cnt;
    pulse_start();
    repeat (3) tick();
    pulse_start();
    repeat (40) tick();
    check("b2b_done_count", done_cnt - d0, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(199) == 0);
      train = ($urandom_range(3) != 0);
      gate = ($urandom_range(7) == 0);
      start = ($urandom_range(15) == 0);
      bus_if.INF_REQ = ($urandom_range(2) == 0);
      bus_if.INF_ADDR = 16'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
